// File: rtl/hiscore_ram_arbiter.sv
// Shares the work-RAM port between the main CPU and the hiscore engine with halt handshake and timeout.
// Optional macro HISCORE_VBLANK_ONLY_EN: the engine may only start a handover during vertical blank.
module hiscore_ram_arbiter #(
   parameter int unsigned AW      = 10,
   parameter int unsigned SETTLE  = 2,
   parameter int unsigned GUARD   = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   input  logic          cpu_we,
   output logic          cpu_pause,
   input  logic          cpu_halted,
   output logic [7:0]    cpu_rdata,
   input  logic          hs_req,
   input  logic [AW-1:0] hs_addr,
   input  logic [7:0]    hs_wdata,
   input  logic          hs_we,
   output logic          hs_gnt,
   output logic [7:0]    hs_rdata,
   input  logic          vblank,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   output logic          ram_we,
   input  logic [7:0]    ram_rdata,
   output logic          busy,
   output logic          timeout_err
);

   localparam int unsigned CW = 4;
   localparam int unsigned TW = 16;

   typedef enum logic [1:0] {
      IDLE,
      HALT_REQ,
      GRANT,
      RELEASE
   } state_t;

   state_t        state;
   logic          armed;
   logic [CW-1:0] settle_cnt;
   logic [CW-1:0] guard_cnt;
   logic [TW-1:0] timeout_cnt;
   logic          start_ok;

`ifdef HISCORE_VBLANK_ONLY_EN
   assign start_ok = hs_req & armed & vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign start_ok      = hs_req & armed;
`endif

   // Handover sequencer; all status outputs are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         armed       <= 1'b1;
         settle_cnt  <= '0;
         guard_cnt   <= '0;
         timeout_cnt <= '0;
         cpu_pause   <= 1'b0;
         hs_gnt      <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!hs_req) armed <= 1'b1;
               if (start_ok) begin
                  state       <= HALT_REQ;
                  cpu_pause   <= 1'b1;
                  busy        <= 1'b1;
                  settle_cnt  <= '0;
                  timeout_cnt <= '0;
               end
            end
            HALT_REQ: begin
               timeout_cnt <= timeout_cnt + TW'(1);
               settle_cnt  <= cpu_halted ? settle_cnt + CW'(1) : '0;
               // Grant beats timeout, timeout beats a withdrawn request.
               if (cpu_halted && (settle_cnt == CW'(SETTLE - 1))) begin
                  state       <= GRANT;
                  hs_gnt      <= 1'b1;
                  timeout_err <= 1'b0;
               end else if (timeout_cnt == TW'(TIMEOUT - 1)) begin
                  state       <= RELEASE;
                  guard_cnt   <= '0;
                  timeout_err <= 1'b1;
                  armed       <= 1'b0;
               end else if (!hs_req) begin
                  state     <= RELEASE;
                  guard_cnt <= '0;
               end
            end
            GRANT: begin
               if (!hs_req) begin
                  state     <= RELEASE;
                  hs_gnt    <= 1'b0;
                  guard_cnt <= '0;
               end
            end
            RELEASE: begin
               guard_cnt <= guard_cnt + CW'(1);
               if (guard_cnt == CW'(GUARD - 1)) begin
                  state     <= IDLE;
                  cpu_pause <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Port mux decoded from registered state only; no write path during handover.
   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      case (state)
         GRANT: begin
            ram_addr  = hs_addr;
            ram_wdata = hs_wdata;
            ram_we    = hs_we;
         end
         HALT_REQ, RELEASE: ram_we = 1'b0;
         default: ;
      endcase
   end

   assign cpu_rdata = ram_rdata;
   assign hs_rdata  = ram_rdata;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Scoreboard bench for hiscore_ram_arbiter: directed handover scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_hiscore_ram_arbiter;

   localparam int unsigned AW      = 10;
   localparam int unsigned SETTLE  = 2;
   localparam int unsigned GUARD   = 2;
   localparam int unsigned TIMEOUT = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] cpu_addr, hs_addr, ram_addr;
   logic [7:0]    cpu_wdata, hs_wdata, ram_wdata, ram_rdata, cpu_rdata, hs_rdata;
   logic          cpu_we, cpu_pause, cpu_halted, hs_req, hs_we, hs_gnt, vblank, ram_we, busy, timeout_err;

   always #5 clk = ~clk;

   hiscore_ram_arbiter #(.AW(AW), .SETTLE(SETTLE), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .cpu_pause(cpu_pause), .cpu_halted(cpu_halted), .cpu_rdata(cpu_rdata),
      .hs_req(hs_req), .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we),
      .hs_gnt(hs_gnt), .hs_rdata(hs_rdata), .vblank(vblank),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .busy(busy), .timeout_err(timeout_err)
   );

   // Work RAM seen by the arbiter.
   logic [7:0] tb_ram [1<<AW];
   always @(posedge clk) if (ram_we) tb_ram[ram_addr] <= ram_wdata;
   assign ram_rdata = tb_ram[ram_addr];

   typedef struct {
      bit            is_mem;
      int            cyc;
      logic          pause, gnt, bsy, err, we;
      logic [AW-1:0] addr;
      logic [7:0]    wdata, rdata;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   active  = 0;

   // Reference model: who owns the port, how long the CPU has been halted, cycles left in the guard.
   bit         m_paused, m_granted, m_armed, m_err;
   int         m_guard_left, m_halt_run, m_wait;
   logic [7:0] m_mem [1<<AW];

   function automatic logic exp_we();
      if (!m_paused) return cpu_we;
      if (m_granted) return hs_we;
      return 1'b0;
   endfunction

   function automatic logic [AW-1:0] exp_addr();
      return m_granted ? hs_addr : cpu_addr;
   endfunction

   function automatic logic [7:0] exp_wdata();
      return m_granted ? hs_wdata : cpu_wdata;
   endfunction

   task automatic model_reset();
      m_paused = 0; m_granted = 0; m_armed = 1; m_err = 0;
      m_guard_left = 0; m_halt_run = 0; m_wait = 0;
   endtask

   task automatic model_edge();
      bit start;
      if (exp_we()) m_mem[exp_addr()] = exp_wdata();
      if (reset) begin
         model_reset();
         return;
      end
`ifdef HISCORE_VBLANK_ONLY_EN
      start = hs_req && m_armed && vblank;
`else
      start = hs_req && m_armed;
`endif
      if (!m_paused) begin
         if (!hs_req) m_armed = 1;
         if (start) begin
            m_paused = 1; m_halt_run = 0; m_wait = 0;
         end
      end else if (m_guard_left > 0) begin
         m_guard_left--;
         if (m_guard_left == 0) m_paused = 0;
      end else if (m_granted) begin
         if (!hs_req) begin
            m_granted = 0; m_guard_left = GUARD;
         end
      end else begin
         m_halt_run = cpu_halted ? m_halt_run + 1 : 0;
         m_wait++;
         if (m_halt_run >= SETTLE) begin
            m_granted = 1; m_err = 0;
         end else if (m_wait >= TIMEOUT) begin
            m_err = 1; m_armed = 0; m_guard_left = GUARD;
         end else if (!hs_req) begin
            m_guard_left = GUARD;
         end
      end
   endtask

   // Next-cycle drive values; applied just after a rising edge.
   logic          d_reset = 1'b1, d_cpu_we = 0, d_hs_req = 0, d_halted = 0, d_hs_we = 0, d_vblank = 0;
   logic [AW-1:0] d_cpu_addr = '0, d_hs_addr = '0;
   logic [7:0]    d_cpu_wdata = '0, d_hs_wdata = '0;

   task automatic apply();
      reset = d_reset; cpu_we = d_cpu_we; cpu_addr = d_cpu_addr; cpu_wdata = d_cpu_wdata;
      hs_req = d_hs_req; hs_we = d_hs_we; hs_addr = d_hs_addr; hs_wdata = d_hs_wdata;
      cpu_halted = d_halted; vblank = d_vblank;
      if (reset) model_reset();
   endtask

   task automatic push_vec();
      exp_t e;
      e.is_mem = 0; e.cyc = cyc;
      e.pause = m_paused; e.gnt = m_granted; e.bsy = m_paused; e.err = m_err;
      e.we = exp_we(); e.addr = exp_addr(); e.wdata = exp_wdata(); e.rdata = m_mem[exp_addr()];
      q.push_back(e);
      active = 1;
   endtask

   task automatic push_mem(input logic [AW-1:0] a, input logic [7:0] v);
      exp_t e;
      e.is_mem = 1; e.cyc = cyc; e.addr = a; e.rdata = v;
      e.pause = 0; e.gnt = 0; e.bsy = 0; e.err = 0; e.we = 0; e.wdata = '0;
      q.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      apply();
      push_vec();
   endtask

   // Reset raised between edges and dropped before the next one.
   task automatic async_reset_pulse();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      apply();
      reset = 1'b1;
      model_reset();
      push_vec();
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: every falling edge compares the DUT against what the stimulus side queued.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (active && q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL no_expectation at time %0t", $time);
         end
         while (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (e.is_mem) begin
               if (tb_ram[e.addr] !== e.rdata) begin
                  n_fail++;
                  $display("FAIL mem[%h] cyc%0d: got %h want %h", e.addr, e.cyc, tb_ram[e.addr], e.rdata);
               end
            end else if ({cpu_pause, hs_gnt, busy, timeout_err, ram_we} !== {e.pause, e.gnt, e.bsy, e.err, e.we} ||
                         ram_addr !== e.addr || ram_wdata !== e.wdata ||
                         cpu_rdata !== e.rdata || hs_rdata !== e.rdata) begin
               n_fail++;
               $display("FAIL outputs cyc%0d: got pause=%b gnt=%b busy=%b err=%b we=%b addr=%h wd=%h crd=%h hrd=%h want pause=%b gnt=%b busy=%b err=%b we=%b addr=%h wd=%h rd=%h",
                        e.cyc, cpu_pause, hs_gnt, busy, timeout_err, ram_we, ram_addr, ram_wdata, cpu_rdata, hs_rdata,
                        e.pause, e.gnt, e.bsy, e.err, e.we, e.addr, e.wdata, e.rdata);
            end
         end
      end
   end

   initial begin
      bit stubborn = 0;
      apply();
      repeat (3) cycle();
      d_reset = 0;
      repeat (6) cycle();

      // Basic grant with one engine write.
      d_hs_req = 1; cycle();
      cycle();
      d_halted = 1; repeat (4) cycle();
      d_hs_addr = 10'h0C4; d_hs_wdata = 8'hA5; d_hs_we = 1; repeat (3) cycle();
      d_hs_we = 0; d_hs_req = 0; repeat (5) cycle();
      d_halted = 0; cycle();
      push_mem(10'h0C4, 8'hA5);

      // Settle restart on a halt glitch.
      d_hs_req = 1; cycle();
      d_halted = 1; cycle();
      d_halted = 0; cycle();
      d_halted = 1; repeat (5) cycle();
      d_hs_req = 0; repeat (4) cycle();
      d_halted = 0; cycle();

      // Timeout with a CPU that never halts; no re-request until hs_req drops.
      d_hs_req = 1; repeat (30) cycle();
      d_hs_req = 0; repeat (2) cycle();
      d_hs_req = 1; cycle();
      d_halted = 1; repeat (5) cycle();
      d_hs_req = 0; repeat (4) cycle();
      d_halted = 0; cycle();

      // Write isolation during handover.
      d_cpu_addr = 10'h010; d_cpu_wdata = 8'h5A; d_cpu_we = 1; cycle();
      d_hs_req = 1; cycle();
      d_cpu_wdata = 8'hFF; repeat (3) cycle();
      d_halted = 1; repeat (4) cycle();
      d_hs_req = 0; repeat (3) cycle();
      d_cpu_we = 0; d_halted = 0; repeat (2) cycle();
      push_mem(10'h010, 8'h5A);

      // Asynchronous reset while the engine holds the port.
      d_hs_req = 1; cycle();
      d_halted = 1; repeat (4) cycle();
      async_reset_pulse();
      d_hs_req = 0; d_halted = 0; repeat (4) cycle();

`ifdef HISCORE_VBLANK_ONLY_EN
      d_vblank = 0; d_hs_req = 1; repeat (50) cycle();
      d_vblank = 1; repeat (2) cycle();
      d_halted = 1; repeat (4) cycle();
      d_hs_req = 0; d_vblank = 0; repeat (4) cycle();
      d_halted = 0; cycle();
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            d_hs_req = ~d_hs_req;
            if (d_hs_req) stubborn = ($urandom_range(0, 3) == 0);
         end
         if (m_paused && !m_granted) d_halted = stubborn ? 1'b0 : 1'($urandom_range(0, 5) != 0);
         else if (m_granted)         d_halted = 1'($urandom_range(0, 1));
         else                        d_halted = 1'b0;
         d_cpu_we    = 1'($urandom_range(0, 3) == 0);
         d_cpu_addr  = AW'($urandom);
         d_cpu_wdata = 8'($urandom);
         d_hs_we     = 1'($urandom_range(0, 1));
         d_hs_addr   = AW'($urandom);
         d_hs_wdata  = 8'($urandom);
         if ($urandom_range(0, 19) == 0) d_vblank = ~d_vblank;
         if ($urandom_range(0, 599) == 0) async_reset_pulse();
         else cycle();
      end

      d_hs_req = 0; d_cpu_we = 0; d_hs_we = 0; d_halted = 0;
      repeat (6) cycle();
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hiscore_ram_arbiter.md
# hiscore_ram_arbiter

Shares the single game work-RAM port between the main CPU and the hiscore save/restore engine. On an engine request it pauses the CPU, waits for a stable halt acknowledge, hands the RAM port to the engine, then returns the port and releases the pause after a guard interval. It sits between the CPU bus decode and the work-RAM instance, next to the hiscore engine, and includes a timeout so a CPU that never halts cannot hang the system.

## Interface
- AW, 10: RAM address width.
- SETTLE, 2: number of consecutive `cpu_halted` cycles required before a grant (1..15).
- GUARD, 2: number of cycles `cpu_pause` stays high after the port is returned (1..15).
- TIMEOUT, 1024: number of HALT_REQ cycles before abort (1..65535; 16-bit counter).

- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cpu_addr  in  AW  CPU RAM address.
- cpu_wdata  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_pause  out  1  halt request to the CPU.
- cpu_halted  in  1  CPU halt acknowledge.
- hs_req  in  1  engine access request, level.
- hs_addr  in  AW  engine RAM address.
- hs_wdata  in  8  engine write data.
- hs_we  in  1  engine write strobe.
- hs_gnt  out  1  engine owns the RAM port.
- vblank  in  1  video vertical blank (used only under the macro).
- ram_addr  out  AW  muxed RAM address.
- ram_wdata  out  8  muxed write data.
- ram_we  out  1  muxed write enable.
- ram_rdata  in  8  RAM read data; fanned out unchanged to both requesters.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky abort flag.

## Operation
- States: IDLE, HALT_REQ, GRANT, RELEASE. Encoding is a local choice.
- IDLE:
  - CPU owns the port: `ram_* = cpu_*`.
  - `hs_req=1` and `armed=1` → HALT_REQ; clear the settle and timeout counters.
- HALT_REQ:
  - `cpu_pause=1`; `ram_we=0`; `ram_addr` and `ram_wdata` follow the CPU.
  - Settle counter increments while `cpu_halted=1` and resets to 0 when `cpu_halted=0`.
  - Timeout counter increments every cycle.
  - Settle count reaches SETTLE → GRANT; clear `timeout_err`.
  - Otherwise, timeout count reaches TIMEOUT → RELEASE; set `timeout_err`; clear `armed`.
  - Otherwise, `hs_req=0` → RELEASE (abort, no error).
- GRANT:
  - `hs_gnt=1`, `cpu_pause=1`, `ram_* = hs_*`.
  - `cpu_halted` is ignored in this state.
  - `hs_req=0` → RELEASE.
- RELEASE:
  - `hs_gnt=0`, `cpu_pause=1`, `ram_we=0`, address and data follow the CPU.
  - Guard counter runs for GUARD cycles, then → IDLE.
- `armed`:
  - Set when `hs_req=0` is sampled in IDLE.
  - Cleared on timeout.
  - This prevents an immediate re-halt loop after a timeout.
- Mux select decodes only from registered state; `ram_*` are combinational from that select.
- `ram_rdata` goes to both requesters without registering.

## Timing
- Reset values: `cpu_pause=0`, `hs_gnt=0`, `busy=0`, `timeout_err=0`, `ram_we` follows `cpu_we`, state=IDLE, `armed=1`, all counters 0.
- `hs_req` high at edge N (IDLE): `cpu_pause=1` and `busy=1` from N+1.
- With `cpu_halted` held high from N+1: `hs_gnt=1` from cycle N+1+SETTLE.
- `hs_req` low at edge M (GRANT): `hs_gnt=0` from M+1; `cpu_pause=0` from M+1+GUARD.
- An engine write lands on the edge where both `hs_gnt=1` and `hs_we=1`.
- There is no write path in HALT_REQ or RELEASE, so no CPU or engine write can occur during handover.
- Any `cpu_halted` glitch low in HALT_REQ restarts the settle count.
- Reset asserted mid-GRANT: `hs_gnt` and `cpu_pause` drop asynchronously and the port returns to the CPU.
- `hs_req` and the timeout expiring on the same edge: timeout wins, so `timeout_err=1`.

## Configuration
- `HISCORE_VBLANK_ONLY_EN` defined:
  - The IDLE→HALT_REQ transition additionally requires `vblank=1`.
  - A grant in progress is not cut when vblank ends.
- Not defined: `vblank` is unused and the transition requires only `hs_req` and `armed`.

## Test plan
- Basic grant: reset, `hs_req=1` at cycle 10, `cpu_halted=1` from cycle 12 → `hs_gnt` rises at 14; with hs_addr=0x0C4, hs_wdata=0xA5, hs_we=1 → RAM[0x0C4]=0xA5; drop `hs_req` at 20 → `hs_gnt=0` at 21, `cpu_pause=0` at 23.
- Settle restart: `cpu_halted` toggles 1,0,1,1 in HALT_REQ → grant only after the final two consecutive highs.
- Timeout: TIMEOUT=16, `cpu_halted=0`, `hs_req` held high → `timeout_err=1` after 16 cycles, then RELEASE→IDLE with no re-request until `hs_req` has been low for one cycle.
- Write isolation: `cpu_we=1` with cpu_addr=0x010 throughout HALT_REQ and RELEASE → RAM[0x010] unchanged.
- Async reset mid-GRANT: `reset` pulsed between edges → `hs_gnt=0` and `cpu_pause=0` immediately, without waiting for a clock.
- Macro on: `hs_req=1` with `vblank=0` for 50 cycles → `cpu_pause` stays 0; `vblank` rises → `cpu_pause=1` on the next cycle.
